// File: rtl/peripheral.sv
// Memory-mapped up/down counter with sticky zero flag and interrupt,
// plus a 256x32 scratch RAM on an independent bus port.
module peripheral (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic [1:0]  reg_address,
  input  logic [31:0] reg_data_in,
  output logic        reg_read_valid,
  output logic [31:0] reg_data_out,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  mem_address,
  input  logic [31:0] mem_data_in,
  output logic        mem_read_valid,
  output logic [31:0] mem_data_out,
  output logic        irq
);

  logic [31:0] count_q, count_d;
  logic [2:0]  cfg_q, cfg_d;
  logic        zf_q, zf_d;
  logic [31:0] cnt_step;
  logic        cnt_wr;

  logic [31:0] reg_rdata_d, reg_rdata_q;
  logic        reg_pend_q;
  logic        reg_valid_q;
  logic [31:0] reg_dout_q;

  logic [31:0] mem_q [256];
  logic [31:0] mem_rdata_q;
  logic        mem_pend_q;
  logic        mem_valid_q;
  logic [31:0] mem_dout_q;

  assign cnt_step = cfg_q[1] ? count_q + 32'd1 : count_q - 32'd1;
  assign cnt_wr   = reg_write && (reg_address == 2'd0);

  always_comb begin
    count_d = count_q;
    cfg_d   = cfg_q;
    zf_d    = zf_q;
    if (cfg_q[0])
      count_d = cnt_step;
    if (cnt_wr)
      count_d = reg_data_in;
    if (reg_write && (reg_address == 2'd1))
      cfg_d = reg_data_in[2:0];
    if (reg_write && (reg_address == 2'd2) && reg_data_in[0])
      zf_d = 1'b0;
    // a step reaching zero sets ZF even against a same-cycle clear; a load does not
    if (cfg_q[0] && !cnt_wr && (cnt_step == '0))
      zf_d = 1'b1;
  end

  always_comb begin
    reg_rdata_d = '0;
    case (reg_address)
      2'd0:    reg_rdata_d = count_q;
      2'd1:    reg_rdata_d = {29'd0, cfg_q};
      2'd2:    reg_rdata_d = {31'd0, zf_q};
      default: reg_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      cfg_q       <= '0;
      zf_q        <= 1'b0;
      reg_rdata_q <= '0;
      reg_pend_q  <= 1'b0;
      reg_valid_q <= 1'b0;
      reg_dout_q  <= '0;
    end else begin
      count_q     <= count_d;
      cfg_q       <= cfg_d;
      zf_q        <= zf_d;
      reg_pend_q  <= reg_read;
      reg_valid_q <= reg_pend_q;
      if (reg_read)
        reg_rdata_q <= reg_rdata_d;
      if (reg_pend_q)
        reg_dout_q <= reg_rdata_q;
    end
  end

  // RAM has no reset; read captures the pre-write word on a same-cycle collision
  always_ff @(posedge clk) begin
    if (mem_write)
      mem_q[mem_address] <= mem_data_in;
    if (mem_read)
      mem_rdata_q <= mem_q[mem_address];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_pend_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dout_q  <= '0;
    end else begin
      mem_pend_q  <= mem_read;
      mem_valid_q <= mem_pend_q;
      if (mem_pend_q)
        mem_dout_q <= mem_rdata_q;
    end
  end

  assign reg_read_valid = reg_valid_q;
  assign reg_data_out   = reg_dout_q;
  assign mem_read_valid = mem_valid_q;
  assign mem_data_out   = mem_dout_q;
  assign irq            = cfg_q[2] & zf_q;

endmodule

// File: tb/tb_peripheral.sv
// Scoreboard bench for peripheral: stimulus queues expected read data,
// monitors pop and compare on each read_valid pulse.
module tb_peripheral;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_read = 1'b0, reg_write = 1'b0;
  logic [1:0]  reg_address = '0;
  logic [31:0] reg_data_in = '0;
  logic        reg_read_valid;
  logic [31:0] reg_data_out;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [7:0]  mem_address = '0;
  logic [31:0] mem_data_in = '0;
  logic        mem_read_valid;
  logic [31:0] mem_data_out;
  logic        irq;

  peripheral dut (
    .clk(clk), .reset(reset),
    .reg_read(reg_read), .reg_write(reg_write), .reg_address(reg_address),
    .reg_data_in(reg_data_in), .reg_read_valid(reg_read_valid), .reg_data_out(reg_data_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_read_valid(mem_read_valid), .mem_data_out(mem_data_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int unsigned due;
  } exp_t;

  exp_t        rq[$];
  exp_t        mq[$];
  int unsigned cyc = 0;
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    while (rq.size() > 0 && rq[0].due < cyc) begin
      nvec++; nerr++;
      $display("FAIL reg_missing_valid: no pulse by cycle %0d, required data %h", rq[0].due, rq[0].d);
      void'(rq.pop_front());
    end
    if (reg_read_valid) begin
      nvec++;
      if (rq.size() == 0) begin
        nerr++;
        $display("FAIL reg_unexpected_valid: cycle %0d data %h, required no pulse", cyc, reg_data_out);
      end else begin
        e = rq.pop_front();
        if (reg_data_out !== e.d || e.due != cyc) begin
          nerr++;
          $display("FAIL reg_read: got %h at cycle %0d, required %h at cycle %0d", reg_data_out, cyc, e.d, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    while (mq.size() > 0 && mq[0].due < cyc) begin
      nvec++; nerr++;
      $display("FAIL mem_missing_valid: no pulse by cycle %0d, required data %h", mq[0].due, mq[0].d);
      void'(mq.pop_front());
    end
    if (mem_read_valid) begin
      nvec++;
      if (mq.size() == 0) begin
        nerr++;
        $display("FAIL mem_unexpected_valid: cycle %0d data %h, required no pulse", cyc, mem_data_out);
      end else begin
        e = mq.pop_front();
        if (mem_data_out !== e.d || e.due != cyc) begin
          nerr++;
          $display("FAIL mem_read: got %h at cycle %0d, required %h at cycle %0d", mem_data_out, cyc, e.d, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    reg_address = a; reg_data_in = d; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [31:0] exp);
    rq.push_back('{d: exp, due: cyc + 2});
    reg_address = a; reg_read = 1'b1;
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic reg_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp);
    rq.push_back('{d: exp, due: cyc + 2});
    reg_address = a; reg_data_in = d; reg_read = 1'b1; reg_write = 1'b1;
    @(negedge clk);
    reg_read = 1'b0; reg_write = 1'b0;
  endtask

  task automatic mem_wr(input logic [7:0] a, input logic [31:0] d);
    mem_address = a; mem_data_in = d; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic mem_rd(input logic [7:0] a, input logic [31:0] exp);
    mq.push_back('{d: exp, due: cyc + 2});
    mem_address = a; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic mem_rw(input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp);
    mq.push_back('{d: exp, due: cyc + 2});
    mem_address = a; mem_data_in = d; mem_read = 1'b1; mem_write = 1'b1;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for 10 clocks
    idle(10);
    chk("rst_reg_valid", {31'd0, reg_read_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("rst_reg_data", reg_data_out, 32'd0);
    chk("rst_mem_data", mem_data_out, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    reg_rd(2'd0, 32'd0);
    reg_rd(2'd1, 32'd0);
    reg_rd(2'd2, 32'd0);
    idle(2);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    // load and count up then down
    reg_wr(2'd0, 32'd67);
    reg_rd(2'd0, 32'd67);
    reg_rd(2'd1, 32'd0);
    reg_wr(2'd1, 32'd3);
    idle(1000);
    reg_wr(2'd1, 32'd7);
    reg_rd(2'd0, 32'd1068);
    reg_wr(2'd1, 32'd5);
    reg_rd(2'd0, 32'd1070);
    reg_rd(2'd0, 32'd1069);
    reg_rd(2'd0, 32'd1068);
    reg_rd(2'd3, 32'd0);
    reg_wr(2'd3, 32'hFFFF_FFFF);
    reg_rd(2'd1, 32'd5);
    reg_rd(2'd2, 32'd0);
    chk("count_irq_low", {31'd0, irq}, 32'd0);

    // wrap going up with interrupt enabled
    reg_wr(2'd1, 32'd0);
    reg_wr(2'd0, 32'hFFFF_FFFE);
    reg_wr(2'd1, 32'd7);
    idle(1);
    chk("wrap_irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    chk("wrap_irq_set", {31'd0, irq}, 32'd1);
    reg_wr(2'd1, 32'd4);
    reg_rd(2'd2, 32'd1);
    chk("wrap_irq_hold", {31'd0, irq}, 32'd1);
    reg_wr(2'd2, 32'd1);
    chk("clear_irq", {31'd0, irq}, 32'd0);
    reg_rd(2'd2, 32'd0);
    reg_rd(2'd0, 32'd1);

    // ZF set with interrupt disabled
    reg_wr(2'd0, 32'hFFFF_FFFF);
    reg_wr(2'd1, 32'd3);
    idle(1);
    reg_wr(2'd1, 32'd0);
    chk("ie0_irq", {31'd0, irq}, 32'd0);
    reg_rd(2'd2, 32'd1);
    reg_rd(2'd0, 32'd1);
    reg_wr(2'd2, 32'd1);
    reg_rd(2'd2, 32'd0);

    // count down to zero; clear in the same cycle loses to set
    reg_wr(2'd0, 32'd3);
    reg_wr(2'd1, 32'd5);
    idle(2);
    reg_wr(2'd2, 32'd1);
    chk("down_irq_set", {31'd0, irq}, 32'd1);
    reg_rd(2'd2, 32'd1);
    reg_rd(2'd0, 32'hFFFF_FFFF);
    reg_rd(2'd0, 32'hFFFF_FFFE);
    reg_wr(2'd2, 32'd1);
    reg_wr(2'd0, 32'd0);
    reg_rd(2'd2, 32'd0);
    reg_rd(2'd0, 32'hFFFF_FFFF);
    chk("load0_irq", {31'd0, irq}, 32'd0);
    reg_wr(2'd1, 32'd0);

    // read+write in one cycle returns old value, write lands
    reg_wr(2'd0, 32'h1234_5678);
    reg_rw(2'd0, 32'hAAAA_0000, 32'h1234_5678);
    reg_rd(2'd0, 32'hAAAA_0000);
    reg_wr(2'd0, 32'h1234_5678);

    // memory fill and readback
    for (int unsigned i = 0; i < 256; i++)
      mem_wr(8'(i), 32'(1024 + 4 * i));
    for (int unsigned i = 0; i < 256; i++) begin
      if (i == 100) begin
        fork
          mem_rd(8'(i), 32'(1024 + 4 * i));
          reg_rd(2'd0, 32'h1234_5678);
        join
      end else begin
        mem_rd(8'(i), 32'(1024 + 4 * i));
      end
    end
    mem_rw(8'd5, 32'hDEAD_BEEF, 32'd1044);
    mem_rd(8'd5, 32'hDEAD_BEEF);
    mem_rd(8'd255, 32'd2044);
    reg_rd(2'd0, 32'h1234_5678);
    idle(3);

    // reset during a pending read cancels the pulse
    reg_address = 2'd0;
    reg_read = 1'b1;
    mem_address = 8'd1;
    mem_read = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    reg_read = 1'b0;
    mem_read = 1'b0;
    chk("midrd_reg_valid", {31'd0, reg_read_valid}, 32'd0);
    idle(1);
    chk("midrd_reg_valid2", {31'd0, reg_read_valid}, 32'd0);
    chk("midrd_mem_valid2", {31'd0, mem_read_valid}, 32'd0);
    chk("midrd_reg_data", reg_data_out, 32'd0);
    chk("midrd_mem_data", mem_data_out, 32'd0);
    idle(1);
    reset = 1'b1;
    reg_rd(2'd0, 32'd0);
    reg_rd(2'd1, 32'd0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
